// File: rtl/count_arb_pkg.sv
// count_arb_pkg: shared types and constants for the count_arbiter block.
//   state_e         FSM state encoding (IDLE, RUN, DONE)
//   NREQ            number of requesters sharing the counter
//   CNT_W_DEFAULT   default counter width
package count_arb_pkg;

  localparam int NREQ          = 2;
  localparam int CNT_W_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : count_arb_pkg

// File: rtl/cnt_core.sv
// cnt_core: CNT_W-bit synchronous up-counter.
//   clk    rising-edge clock
//   rst    asynchronous active-low reset (count -> 0)
//   clr    synchronous clear; wins over en
//   en     count enable
//   cnt_q  current count
module cnt_core
  import count_arb_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt_q
);

  logic [CNT_W-1:0] cnt_d;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : cnt_core

// File: rtl/count_arbiter.sv
// count_arbiter: shares one cnt_core counter between two requesters, each
// asking for a timed interval of programmable length.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset
//   req    per-requester request level, held until the matching done
//   len0   requester 0 terminal count, sampled at grant
//   len1   requester 1 terminal count, sampled at grant
//   abort  cancels the active interval (ignored outside RUN)
//   gnt    registered one-hot grant
//   done   one-cycle completion pulse to the granted requester
//   busy   high whenever the FSM is not IDLE
//   cnt_q  live counter value
//
// Configuration:
//   COUNT_ARB_RR_EN defined   -> round-robin between simultaneous requests
//   COUNT_ARB_RR_EN undefined -> fixed priority, req[0] beats req[1]
module count_arbiter
  import count_arb_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [CNT_W-1:0] len0,
  input  logic [CNT_W-1:0] len1,
  input  logic             abort,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_q
);

  state_e           state_q;
  logic [NREQ-1:0]  gnt_q;
  logic [NREQ-1:0]  done_q;
  logic [CNT_W-1:0] len_q;

  logic             win_idx;
  logic [NREQ-1:0]  win_oh;
  logic [CNT_W-1:0] len_sel;
  logic             at_term;
  logic             cnt_clr;
  logic             cnt_en;

`ifdef COUNT_ARB_RR_EN
  // Index of the requester served last; reset to 1 so requester 0 is
  // favoured first.
  logic             last_q;
`endif

  // Winner selection, only meaningful while some req is high in IDLE.
  always_comb begin
`ifdef COUNT_ARB_RR_EN
    if (req[0] && req[1]) begin
      win_idx = ~last_q;
    end else begin
      win_idx = ~req[0];
    end
`else
    win_idx = ~req[0];
`endif
    win_oh  = win_idx ? 2'b10 : 2'b01;
    len_sel = win_idx ? len1 : len0;
  end

  // Counter control: held at zero outside RUN and on abort; stops at the
  // terminal count so it never wraps, even for an all-ones length.
  assign at_term = (cnt_q == len_q);
  assign cnt_clr = (state_q != RUN) || abort;
  assign cnt_en  = (state_q == RUN) && !at_term;

  cnt_core #(
    .CNT_W (CNT_W)
  ) u_cnt_core (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt_q (cnt_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      len_q   <= '0;
`ifdef COUNT_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= '0;
          if (|req) begin
            gnt_q   <= win_oh;
            len_q   <= len_sel;
            state_q <= RUN;
          end
        end
        RUN: begin
          // Abort outranks the terminal count; an aborted grant still
          // counts as served for the round-robin pointer.
          if (abort) begin
            gnt_q   <= '0;
            state_q <= IDLE;
`ifdef COUNT_ARB_RR_EN
            last_q  <= gnt_q[1];
`endif
          end else if (at_term) begin
            done_q  <= gnt_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= '0;
          gnt_q   <= '0;
          state_q <= IDLE;
`ifdef COUNT_ARB_RR_EN
          last_q  <= gnt_q[1];
`endif
        end
        default: begin
          gnt_q   <= '0;
          done_q  <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

endmodule : count_arbiter

// File: tb/tb_count_arbiter.sv
// tb_count_arbiter: directed, scoreboard-based bench for count_arbiter.
// Expected per-cycle outputs are queued when a stimulus step is set up and
// compared one entry per clock, #1 after the rising edge.
module tb_count_arbiter;
  import count_arb_pkg::*;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic [1:0] req   = 2'b00;
  logic [2:0] len0  = 3'd0;
  logic [2:0] len1  = 3'd0;
  logic       abort = 1'b0;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       busy;
  logic [2:0] cnt_q;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic [2:0] cnt;
  } exp_t;

  exp_t  sb[$];
  string tq[$];

  count_arbiter #(.CNT_W(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .len0  (len0),
    .len1  (len1),
    .abort (abort),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .cnt_q (cnt_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [1:0] g, input logic [1:0] d,
                      input logic b, input logic [2:0] c);
    exp_t e;
    e.gnt  = g;
    e.done = d;
    e.busy = b;
    e.cnt  = c;
    sb.push_back(e);
    tq.push_back(tag);
  endtask

  // One clock: sample after the edge and compare against the oldest entry.
  task automatic step();
    exp_t  e;
    string t;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: observed empty queue, expected an entry");
    end else begin
      e = sb.pop_front();
      t = tq.pop_front();
      check({t, ".gnt"},  {6'd0, gnt},   {6'd0, e.gnt});
      check({t, ".done"}, {6'd0, done},  {6'd0, e.done});
      check({t, ".busy"}, {7'd0, busy},  {7'd0, e.busy});
      check({t, ".cnt"},  {5'd0, cnt_q}, {5'd0, e.cnt});
    end
  endtask

  // Expected outputs for a full interval of length L granted to g,
  // starting at the edge that sees the request (edge k).
  task automatic push_interval(input string tag, input logic [1:0] g, input int L);
    push($sformatf("%s@k", tag), g, 2'b00, 1'b1, 3'd0);
    for (int i = 1; i <= L; i++) begin
      push($sformatf("%s@k+%0d", tag, i), g, 2'b00, 1'b1, 3'(i));
    end
    push($sformatf("%s@done", tag), g, g, 1'b1, 3'(L));
    push($sformatf("%s@end", tag), 2'b00, 2'b00, 1'b0, 3'd0);
  endtask

  // Full interval; requester bits in 'drop' deassert on the edge ending done.
  task automatic run_interval(input string tag, input logic [1:0] g, input int L,
                              input logic [1:0] drop);
    push_interval(tag, g, L);
    repeat (L + 3) step();
    req = req & ~drop;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state while rst is held low.
    #2;
    check("rst.gnt",  {6'd0, gnt},   8'd0);
    check("rst.done", {6'd0, done},  8'd0);
    check("rst.busy", {7'd0, busy},  8'd0);
    check("rst.cnt",  {5'd0, cnt_q}, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    push("idle0", 2'b00, 2'b00, 1'b0, 3'd0);
    step();

    // Requester 0, len 5: cnt 0..5, done after k+6, idle after k+7.
    req  = 2'b01;
    len0 = 3'd5;
    run_interval("len5", 2'b01, 5, 2'b01);

    // Requester 1, zero-length interval.
    req  = 2'b10;
    len1 = 3'd0;
    run_interval("len0", 2'b10, 0, 2'b10);

    // Abort at cnt 3, then abort while idle has no effect.
    req  = 2'b01;
    len0 = 3'd7;
    for (int i = 0; i <= 3; i++) begin
      push($sformatf("abrt@k+%0d", i), 2'b01, 2'b00, 1'b1, 3'(i));
    end
    repeat (4) step();
    req   = 2'b00;
    abort = 1'b1;
    push("abrt@a", 2'b00, 2'b00, 1'b0, 3'd0);
    step();
    push("abrt_idle", 2'b00, 2'b00, 1'b0, 3'd0);
    step();
    abort = 1'b0;

    // Abort coincident with terminal count: abort wins, no done.
    req  = 2'b10;
    len1 = 3'd2;
    for (int i = 0; i <= 2; i++) begin
      push($sformatf("abrt_tc@k+%0d", i), 2'b10, 2'b00, 1'b1, 3'(i));
    end
    repeat (3) step();
    req   = 2'b00;
    abort = 1'b1;
    push("abrt_tc@a", 2'b00, 2'b00, 1'b0, 3'd0);
    step();
    abort = 1'b0;
    push("abrt_tc@a+1", 2'b00, 2'b00, 1'b0, 3'd0);
    step();

    // Full-length run to 7 with req[1] arriving mid-run and len0 changing
    // mid-run (ignored); req[1] is granted at k+10.
    req  = 2'b01;
    len0 = 3'd7;
    len1 = 3'd1;
    push_interval("full7", 2'b01, 7);
    repeat (3) step();
    req  = 2'b11;
    len0 = 3'd2;
    repeat (7) step();
    req = 2'b10;
    run_interval("pend1", 2'b10, 1, 2'b10);

    // Both requesters held continuously.
    req  = 2'b11;
    len0 = 3'd2;
    len1 = 3'd3;
`ifdef COUNT_ARB_RR_EN
    run_interval("both_a", 2'b01, 2, 2'b00);
    run_interval("both_b", 2'b10, 3, 2'b00);
    run_interval("both_c", 2'b01, 2, 2'b00);
    run_interval("both_d", 2'b10, 3, 2'b11);
`else
    run_interval("both_a", 2'b01, 2, 2'b00);
    run_interval("both_b", 2'b01, 2, 2'b00);
    run_interval("both_c", 2'b01, 2, 2'b11);
`endif
    push("both_idle", 2'b00, 2'b00, 1'b0, 3'd0);
    step();

    // Asynchronous reset mid-run at cnt 4.
    req  = 2'b01;
    len0 = 3'd6;
    for (int i = 0; i <= 4; i++) begin
      push($sformatf("arst@k+%0d", i), 2'b01, 2'b00, 1'b1, 3'(i));
    end
    repeat (5) step();
    #2;
    rst = 1'b0;
    #1;
    check("arst.gnt",  {6'd0, gnt},   8'd0);
    check("arst.done", {6'd0, done},  8'd0);
    check("arst.busy", {7'd0, busy},  8'd0);
    check("arst.cnt",  {5'd0, cnt_q}, 8'd0);
    req = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push($sformatf("arst_post%0d", i), 2'b00, 2'b00, 1'b0, 3'd0);
    end
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_count_arbiter

// File: doc/count_arbiter.md
# count_arbiter

Controller that shares one CNT_W-bit up-counter (the 3-bit synchronous counter datapath) between two requesters, each asking for a timed interval of a programmable length. It arbitrates requests and clears and enables the counter. It detects the terminal count, returns a one-cycle done pulse to the winning requester, and supports abort of an in-flight interval. It sits between requester logic and the counter core, and owns the core exclusively.

## Interface
- CNT_W, 3, counter width; interval length range 0..2^CNT_W-1
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous active-low reset
- req  input  2  per-requester request level; held high until matching done[i]
- len0  input  CNT_W  requester 0 terminal count; sampled only at grant
- len1  input  CNT_W  requester 1 terminal count; sampled only at grant
- abort  input  1  cancels the active interval; ignored when idle
- gnt  output  2  one-hot grant; registered
- done  output  2  one-cycle completion pulse to the granted requester
- busy  output  1  high whenever state is not IDLE
- cnt_q  output  CNT_W  live counter value

## Operation
- States: IDLE, RUN, DONE. Reset values: state IDLE, gnt 0, done 0, busy 0, cnt_q 0, round-robin pointer favours requester 0.
- IDLE, any req high:
  - Pick the winner per arbitration policy.
  - gnt <= onehot(winner), len_r <= len of the winner, cnt <= 0.
  - Go to RUN.
- IDLE, no req: hold state, cnt 0.
- RUN, priority order:
  - abort: gnt <= 0, cnt <= 0, go to IDLE, no done.
  - else if cnt == len_r: done[winner] <= 1, cnt holds, go to DONE.
  - else cnt <= cnt + 1 (counter enable high).
- DONE: done <= 0, gnt <= 0, cnt <= 0, pointer <= winner, go to IDLE.
- Abort also updates the pointer, so an aborted grant counts as served.
- Width rule: cnt never exceeds len_r, so there is no wrap-around. len = 2^CNT_W-1 (7 at default) is legal and reaches all-ones.
- req or len changes during RUN/DONE are ignored. The non-granted request waits.
- Requester protocol: deassert req on the edge ending the done cycle. A req still high at the next IDLE edge is a new request.
- Simultaneous abort and terminal count: abort wins, no done.
- abort in IDLE or DONE: no effect.
- Async reset at any point: immediate return to reset values. No done is emitted for the interrupted interval.

## Timing
- Grant latency: req high at IDLE edge k gives gnt and cnt=0 after edge k.
- cnt = L after edge k+L; done high after edge k+L+1; gnt and done low after edge k+L+2.
- Earliest next grant: edge k+L+3. Total cost per interval is L+3 cycles.
- Abort sampled at edge a in RUN: gnt 0, cnt 0 after edge a. A new grant is possible at edge a+1.
- busy: high from edge k through edge k+L+2 exclusive; combinational decode of state.

## Configuration
- COUNT_ARB_RR_EN defined: round-robin. On simultaneous requests the requester not served last wins. A requester holding req continuously alternates with the other.
- Undefined: fixed priority; req[0] always beats req[1]. The pointer register is not implemented.

## Structure
- Package count_arb_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - NREQ = 2
  - default CNT_W
- Sub-module cnt_core: CNT_W-bit synchronous up-counter with async active-low rst, sync clr, and en; clr has priority over en. It is instantiated once. All arbitration and FSM logic stays in count_arbiter.

## Test plan
- Reset low mid-RUN with cnt=4 → gnt, done, busy, cnt_q all 0 immediately; after release, state IDLE and no done pulse.
- req=01, len0=5 at edge k → gnt=01 after k; cnt_q 0..5 over k..k+5; done=01 after k+6; gnt=00 after k+7.
- req=11, len0=2, len1=3, both held, COUNT_ARB_RR_EN defined → grant order 01,10,01,10; without the macro → 01,01,01.
- len1=0 with req=10 → gnt=10 after k, done=10 after k+1, gnt=00 after k+2.
- len0=7, abort asserted when cnt_q=3 → gnt=00 and cnt_q=0 after that edge, no done; abort coincident with cnt_q==len → no done.
- len0=7 full run → cnt_q reaches 7 without wrap, done after edge k+8; pending req[1] is granted at edge k+10.
